// File: rtl/mure_uop_coalescer.sv
// mure_uop_coalescer: buffers up to NRET retired uops per cycle in a lane-ordered
// FIFO and coalesces runs of STD uops into block packets for the trace encoder.
// Optional feature macro: MURE_TIMESTAMP_EN (adds TS_LEN and pkt_time_o).
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   uop_*_i, uop_ready_o     commit-port input side (NRET lanes, contiguous from lane 0)
//   pkt_*_o, pkt_ready_i     packet output, valid/ready handshake
//   overflow_o               sticky: valid input seen while uop_ready_o was low

package mure_pkg;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned ITYPE_LEN   = 4;
    localparam int unsigned IRETIRE_LEN = 14;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    typedef enum logic [3:0] {
        ITYPE_STD  = 4'd0,
        ITYPE_EXC  = 4'd1,
        ITYPE_INT  = 4'd2,
        ITYPE_ERET = 4'd3,
        ITYPE_NTB  = 4'd4,
        ITYPE_TB   = 4'd5
    } itype_e;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } exc_info_s;
endpackage

module mure_uop_coalescer #(
    parameter int unsigned NRET        = 2,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned XLEN        = mure_pkg::XLEN,
    parameter int unsigned ITYPE_LEN   = mure_pkg::ITYPE_LEN,
    parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
    parameter int unsigned CAUSE_LEN   = mure_pkg::CAUSE_LEN,
    parameter int unsigned PRIV_LEN    = mure_pkg::PRIV_LEN
`ifdef MURE_TIMESTAMP_EN
    ,
    parameter int unsigned TS_LEN      = 32
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NRET-1:0]               uop_valid_i,
    input  logic [NRET*XLEN-1:0]          uop_pc_i,
    input  logic [NRET*ITYPE_LEN-1:0]     uop_itype_i,
    input  logic [NRET-1:0]               uop_compressed_i,
    input  logic [NRET*PRIV_LEN-1:0]      uop_priv_i,
    input  logic [CAUSE_LEN+XLEN-1:0]     uop_exc_i,
    output logic                          uop_ready_o,
    output logic                          pkt_valid_o,
    input  logic                          pkt_ready_i,
    output logic [XLEN-1:0]               pkt_iaddr_o,
    output logic [IRETIRE_LEN-1:0]        pkt_iretire_o,
    output logic [ITYPE_LEN-1:0]          pkt_itype_o,
    output logic [PRIV_LEN-1:0]           pkt_priv_o,
    output logic [CAUSE_LEN+XLEN-1:0]     pkt_exc_o,
`ifdef MURE_TIMESTAMP_EN
    output logic [TS_LEN-1:0]             pkt_time_o,
`endif
    output logic                          overflow_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = $clog2(NRET + 1);
    localparam int unsigned EXC_W  = CAUSE_LEN + XLEN;
    localparam int unsigned SUM_W  = IRETIRE_LEN + 1;

    localparam logic [ITYPE_LEN-1:0] IT_STD = ITYPE_LEN'(mure_pkg::ITYPE_STD);
    localparam logic [ITYPE_LEN-1:0] IT_EXC = ITYPE_LEN'(mure_pkg::ITYPE_EXC);
    localparam logic [ITYPE_LEN-1:0] IT_INT = ITYPE_LEN'(mure_pkg::ITYPE_INT);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [ITYPE_LEN-1:0] itype;
        logic                 comp;
        logic [PRIV_LEN-1:0]  priv;
        logic [EXC_W-1:0]     exc;
    } entry_t;

    typedef enum logic {S_IDLE, S_COUNT} state_e;

    entry_t                 mem_q [DEPTH];
    entry_t                 mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d, n_wr;
    logic                   ready_q, ready_d, overflow_q, overflow_d;
    state_e                 state_q, state_d;
    logic [XLEN-1:0]        iaddr_q, iaddr_d;
    logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
    logic [PRIV_LEN-1:0]    priv_q, priv_d;
    logic                   pkt_valid_q, pkt_valid_d;
    logic [XLEN-1:0]        pkt_iaddr_q, pkt_iaddr_d;
    logic [IRETIRE_LEN-1:0] pkt_iretire_q, pkt_iretire_d;
    logic [ITYPE_LEN-1:0]   pkt_itype_q, pkt_itype_d;
    logic [PRIV_LEN-1:0]    pkt_priv_q, pkt_priv_d;
    logic [EXC_W-1:0]       pkt_exc_q, pkt_exc_d;
    logic [LANE_W-1:0]      hi_lane;
    logic [PTR_W-1:0]       widx;
    entry_t                 head;
    logic [SUM_W-1:0]       weight, sum;
    logic                   pop, emit, out_free, head_exc;

    // Write side: all valid lanes land in lane order; exc info goes to the highest valid lane.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        n_wr       = '0;
        hi_lane    = '0;
        widx       = '0;
        overflow_d = overflow_q | ((|uop_valid_i) & ~ready_q);
        for (int i = 0; i < int'(NRET); i++) begin
            if (uop_valid_i[i]) hi_lane = LANE_W'(i);
        end
        if (ready_q) begin
            for (int i = 0; i < int'(NRET); i++) begin
                if (uop_valid_i[i]) begin
                    widx = wr_ptr_q + PTR_W'(i);
                    mem_d[widx].pc    = uop_pc_i[i*XLEN +: XLEN];
                    mem_d[widx].itype = uop_itype_i[i*ITYPE_LEN +: ITYPE_LEN];
                    mem_d[widx].comp  = uop_compressed_i[i];
                    mem_d[widx].priv  = uop_priv_i[i*PRIV_LEN +: PRIV_LEN];
                    mem_d[widx].exc   = (LANE_W'(i) == hi_lane) ? uop_exc_i : '0;
                    n_wr = n_wr + CNT_W'(1);
                end
            end
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
    end

    // Read side: block-building FSM and output register.
    always_comb begin
        state_d       = state_q;
        iaddr_d       = iaddr_q;
        cnt_d         = cnt_q;
        priv_d        = priv_q;
        pop           = 1'b0;
        emit          = 1'b0;
        pkt_iaddr_d   = pkt_iaddr_q;
        pkt_iretire_d = pkt_iretire_q;
        pkt_itype_d   = pkt_itype_q;
        pkt_priv_d    = pkt_priv_q;
        pkt_exc_d     = pkt_exc_q;
        head          = mem_q[rd_ptr_q];
        weight        = head.comp ? SUM_W'(1) : SUM_W'(2);
        sum           = {1'b0, cnt_q} + weight;
        out_free      = ~pkt_valid_q | pkt_ready_i;
        head_exc      = (head.itype == IT_EXC) || (head.itype == IT_INT);

        if (count_q != '0) begin
            case (state_q)
                S_IDLE: begin
                    if (head.itype == IT_STD) begin
                        iaddr_d = head.pc;
                        cnt_d   = IRETIRE_LEN'(weight);
                        priv_d  = head.priv;
                        pop     = 1'b1;
                        state_d = S_COUNT;
                    end else if (out_free) begin
                        emit          = 1'b1;
                        pop           = 1'b1;
                        pkt_iaddr_d   = head.pc;
                        pkt_iretire_d = IRETIRE_LEN'(weight);
                        pkt_itype_d   = head.itype;
                        pkt_priv_d    = head.priv;
                        pkt_exc_d     = head_exc ? head.exc : '0;
                    end
                end
                S_COUNT: begin
                    // Priv change or counter saturation closes the block before the head.
                    if ((head.priv != priv_q) || sum[IRETIRE_LEN]) begin
                        if (out_free) begin
                            emit          = 1'b1;
                            pkt_iaddr_d   = iaddr_q;
                            pkt_iretire_d = cnt_q;
                            pkt_itype_d   = IT_STD;
                            pkt_priv_d    = priv_q;
                            pkt_exc_d     = '0;
                            state_d       = S_IDLE;
                        end
                    end else if (head.itype == IT_STD) begin
                        cnt_d = IRETIRE_LEN'(sum);
                        pop   = 1'b1;
                    end else if (out_free) begin
                        emit          = 1'b1;
                        pop           = 1'b1;
                        pkt_iaddr_d   = iaddr_q;
                        pkt_iretire_d = IRETIRE_LEN'(sum);
                        pkt_itype_d   = head.itype;
                        pkt_priv_d    = priv_q;
                        pkt_exc_d     = head_exc ? head.exc : '0;
                        state_d       = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pkt_valid_d = emit | (pkt_valid_q & ~pkt_ready_i);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + n_wr - CNT_W'(pop);
        ready_d     = (CNT_W'(DEPTH) - count_d) >= CNT_W'(NRET);
    end

    // FIFO storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            overflow_q    <= 1'b0;
            state_q       <= S_IDLE;
            iaddr_q       <= '0;
            cnt_q         <= '0;
            priv_q        <= '0;
            pkt_valid_q   <= 1'b0;
            pkt_iaddr_q   <= '0;
            pkt_iretire_q <= '0;
            pkt_itype_q   <= '0;
            pkt_priv_q    <= '0;
            pkt_exc_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
            iaddr_q       <= iaddr_d;
            cnt_q         <= cnt_d;
            priv_q        <= priv_d;
            pkt_valid_q   <= pkt_valid_d;
            pkt_iaddr_q   <= pkt_iaddr_d;
            pkt_iretire_q <= pkt_iretire_d;
            pkt_itype_q   <= pkt_itype_d;
            pkt_priv_q    <= pkt_priv_d;
            pkt_exc_q     <= pkt_exc_d;
        end
    end

`ifdef MURE_TIMESTAMP_EN
    logic [TS_LEN-1:0] ts_q, ts_d, pkt_time_q, pkt_time_d;

    // Free-running timestamp, sampled into the packet on every emit.
    always_comb begin
        ts_d       = ts_q + TS_LEN'(1);
        pkt_time_d = emit ? ts_q : pkt_time_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            pkt_time_q <= '0;
        end else begin
            ts_q       <= ts_d;
            pkt_time_q <= pkt_time_d;
        end
    end

    assign pkt_time_o = pkt_time_q;
`endif

    assign uop_ready_o   = ready_q;
    assign overflow_o    = overflow_q;
    assign pkt_valid_o   = pkt_valid_q;
    assign pkt_iaddr_o   = pkt_iaddr_q;
    assign pkt_iretire_o = pkt_iretire_q;
    assign pkt_itype_o   = pkt_itype_q;
    assign pkt_priv_o    = pkt_priv_q;
    assign pkt_exc_o     = pkt_exc_q;

endmodule

// File: tb/tb_mure_uop_coalescer.sv
// Directed testbench for mure_uop_coalescer (NRET=2, DEPTH=8, IRETIRE_LEN=4).
module tb_mure_uop_coalescer;

    localparam int unsigned NRET = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ITL = 4;
    localparam int unsigned IRL = 4;
    localparam int unsigned CL = 5;
    localparam int unsigned PL = 2;
    localparam int unsigned EW = CL + XLEN;

    localparam logic [3:0] STD = 4'd0;
    localparam logic [3:0] EXC = 4'd1;
    localparam logic [3:0] NTB = 4'd4;
    localparam logic [3:0] TB  = 4'd5;

    typedef struct packed {
        logic [XLEN-1:0] iaddr;
        logic [IRL-1:0]  iretire;
        logic [ITL-1:0]  itype;
        logic [PL-1:0]   priv;
        logic [EW-1:0]   exc;
    } pkt_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NRET-1:0]      uop_valid_i = '0;
    logic [NRET*XLEN-1:0] uop_pc_i = '0;
    logic [NRET*ITL-1:0]  uop_itype_i = '0;
    logic [NRET-1:0]      uop_compressed_i = '0;
    logic [NRET*PL-1:0]   uop_priv_i = '0;
    logic [EW-1:0]        uop_exc_i = '0;
    logic                 uop_ready_o;
    logic                 pkt_valid_o;
    logic                 pkt_ready_i = 1'b1;
    logic [XLEN-1:0]      pkt_iaddr_o;
    logic [IRL-1:0]       pkt_iretire_o;
    logic [ITL-1:0]       pkt_itype_o;
    logic [PL-1:0]        pkt_priv_o;
    logic [EW-1:0]        pkt_exc_o;
    logic                 overflow_o;
`ifdef MURE_TIMESTAMP_EN
    logic [31:0]          pkt_time_o;
`endif

    int   checks = 0;
    int   failures = 0;
    int   wr_to = 0;
    pkt_t pq[$];
    pkt_t got, exp_p;

    mure_uop_coalescer #(
        .NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .ITYPE_LEN(ITL),
        .IRETIRE_LEN(IRL), .CAUSE_LEN(CL), .PRIV_LEN(PL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .uop_valid_i(uop_valid_i), .uop_pc_i(uop_pc_i), .uop_itype_i(uop_itype_i),
        .uop_compressed_i(uop_compressed_i), .uop_priv_i(uop_priv_i), .uop_exc_i(uop_exc_i),
        .uop_ready_o(uop_ready_o), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
        .pkt_iaddr_o(pkt_iaddr_o), .pkt_iretire_o(pkt_iretire_o), .pkt_itype_o(pkt_itype_o),
        .pkt_priv_o(pkt_priv_o), .pkt_exc_o(pkt_exc_o),
`ifdef MURE_TIMESTAMP_EN
        .pkt_time_o(pkt_time_o),
`endif
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every accepted packet; handshake completes on the following rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && pkt_valid_o && pkt_ready_i)
            pq.push_back('{pkt_iaddr_o, pkt_iretire_o, pkt_itype_o, pkt_priv_o, pkt_exc_o});
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic lane_write(input int n,
                              input logic [31:0] pc0, input logic [3:0] it0, input logic c0, input logic [1:0] p0,
                              input logic [31:0] pc1, input logic [3:0] it1, input logic c1, input logic [1:0] p1,
                              input logic [EW-1:0] exc);
        int t = 0;
        while (!uop_ready_o && t < 100) begin
            cycle();
            t++;
        end
        if (!uop_ready_o) wr_to++;
        uop_valid_i      = (n == 2) ? 2'b11 : 2'b01;
        uop_pc_i         = {pc1, pc0};
        uop_itype_i      = {it1, it0};
        uop_compressed_i = {c1, c0};
        uop_priv_i       = {p1, p0};
        uop_exc_i        = exc;
        cycle();
        uop_valid_i = '0;
        uop_exc_i   = '0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < 300 && pq.size() < n; i++) cycle();
        for (int i = 0; i < 10; i++) cycle();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
        cycle();
        checks++;
        if (pkt_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pkt_valid_o); end
        checks++;
        if (uop_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", uop_ready_o); end
        checks++;
        if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
        checks++;
        if ({pkt_iaddr_o, pkt_iretire_o, pkt_itype_o, pkt_priv_o, pkt_exc_o} !== '0) begin
            failures++;
            $display("FAIL reset_pkt got=%h exp=0", {pkt_iaddr_o, pkt_iretire_o, pkt_itype_o, pkt_priv_o, pkt_exc_o});
        end
    endtask

    task automatic test_block();
        pq.delete();
        wr_to = 0;
        pkt_ready_i = 1'b1;
        lane_write(2, 32'h100, STD, 1'b0, 2'd3, 32'h104, STD, 1'b1, 2'd3, '0);
        lane_write(1, 32'h106, TB, 1'b0, 2'd3, 32'h0, STD, 1'b0, 2'd0, '0);
        settle(1);
        checks++;
        if (pq.size() !== 1 || wr_to != 0) begin failures++; $display("FAIL block_count got=%0d exp=1", pq.size()); end
        else begin
            got = pq.pop_front();
            exp_p = '{32'h100, 4'd5, TB, 2'd3, '0};
            checks++;
            if (got !== exp_p) begin failures++; $display("FAIL block_pkt got=%h exp=%h", got, exp_p); end
        end
    endtask

    task automatic test_exc_latency();
        pq.delete();
        wr_to = 0;
        pkt_ready_i = 1'b1;
        lane_write(1, 32'h200, EXC, 1'b0, 2'd3, 32'h0, STD, 1'b0, 2'd0, {5'd2, 32'h0000DEAD});
        checks++;
        if (pkt_valid_o !== 1'b0 || wr_to != 0) begin failures++; $display("FAIL exc_early got=%b exp=0", pkt_valid_o); end
        cycle();
        checks++;
        if (pkt_valid_o !== 1'b1) begin failures++; $display("FAIL exc_valid_n2 got=%b exp=1", pkt_valid_o); end
        got = '{pkt_iaddr_o, pkt_iretire_o, pkt_itype_o, pkt_priv_o, pkt_exc_o};
        exp_p = '{32'h200, 4'd2, EXC, 2'd3, {5'd2, 32'h0000DEAD}};
        checks++;
        if (got !== exp_p) begin failures++; $display("FAIL exc_pkt got=%h exp=%h", got, exp_p); end
        settle(1);
        checks++;
        if (pq.size() !== 1) begin failures++; $display("FAIL exc_count got=%0d exp=1", pq.size()); end
    endtask

    task automatic test_priv_change();
        pq.delete();
        wr_to = 0;
        pkt_ready_i = 1'b1;
        lane_write(1, 32'h300, STD, 1'b0, 2'd3, 32'h0, STD, 1'b0, 2'd0, '0);
        lane_write(1, 32'h304, NTB, 1'b0, 2'd1, 32'h0, STD, 1'b0, 2'd0, '0);
        settle(2);
        checks++;
        if (pq.size() !== 2 || wr_to != 0) begin failures++; $display("FAIL priv_count got=%0d exp=2", pq.size()); end
        else begin
            got = pq.pop_front();
            exp_p = '{32'h300, 4'd2, STD, 2'd3, '0};
            checks++;
            if (got !== exp_p) begin failures++; $display("FAIL priv_pkt0 got=%h exp=%h", got, exp_p); end
            got = pq.pop_front();
            exp_p = '{32'h304, 4'd2, NTB, 2'd1, '0};
            checks++;
            if (got !== exp_p) begin failures++; $display("FAIL priv_pkt1 got=%h exp=%h", got, exp_p); end
        end
    endtask

    task automatic test_saturation();
        pq.delete();
        wr_to = 0;
        pkt_ready_i = 1'b1;
        for (int k = 0; k < 4; k++)
            lane_write(2, 32'h400 + 32'(8*k), STD, 1'b0, 2'd3, 32'h404 + 32'(8*k), STD, 1'b0, 2'd3, '0);
        lane_write(1, 32'h420, TB, 1'b0, 2'd3, 32'h0, STD, 1'b0, 2'd0, '0);
        settle(2);
        checks++;
        if (pq.size() !== 2 || wr_to != 0) begin failures++; $display("FAIL sat_count got=%0d exp=2", pq.size()); end
        else begin
            got = pq.pop_front();
            exp_p = '{32'h400, 4'd14, STD, 2'd3, '0};
            checks++;
            if (got !== exp_p) begin failures++; $display("FAIL sat_pkt0 got=%h exp=%h", got, exp_p); end
            got = pq.pop_front();
            exp_p = '{32'h41C, 4'd4, TB, 2'd3, '0};
            checks++;
            if (got !== exp_p) begin failures++; $display("FAIL sat_pkt1 got=%h exp=%h", got, exp_p); end
        end
    endtask

    task automatic test_overflow();
        int nw = 0;
        pq.delete();
        pkt_ready_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!uop_ready_o) break;
            uop_valid_i = 2'b11;
            uop_pc_i    = {32'h504 + 32'(8*k), 32'h500 + 32'(8*k)};
            uop_itype_i = {NTB, NTB};
            uop_compressed_i = 2'b00;
            uop_priv_i  = {2'd3, 2'd3};
            cycle();
            nw += 2;
        end
        uop_valid_i = '0;
        checks++;
        if (nw != 8) begin failures++; $display("FAIL ovf_written got=%0d exp=8", nw); end
        uop_valid_i = 2'b11;
        uop_pc_i    = {32'h604, 32'h600};
        cycle();
        uop_valid_i = '0;
        checks++;
        if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
        checks++;
        if (pkt_valid_o !== 1'b1 || pkt_iaddr_o !== 32'h500) begin
            failures++;
            $display("FAIL ovf_hold got=%b/%h exp=1/00000500", pkt_valid_o, pkt_iaddr_o);
        end
        pkt_ready_i = 1'b1;
        settle(8);
        checks++;
        if (pq.size() !== 8) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=8", pq.size()); end
        for (int k = 0; k < 8 && pq.size() > 0; k++) begin
            got = pq.pop_front();
            exp_p = '{32'h500 + 32'(4*k), 4'd2, NTB, 2'd3, '0};
            checks++;
            if (got !== exp_p) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", k, got, exp_p); end
        end
        checks++;
        if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    endtask

    task automatic test_reset_mid_block();
        pq.delete();
        wr_to = 0;
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        cycle();
        pkt_ready_i = 1'b0;
        lane_write(1, 32'h700, EXC, 1'b0, 2'd3, 32'h0, STD, 1'b0, 2'd0, {5'd7, 32'h1234});
        lane_write(1, 32'h704, STD, 1'b0, 2'd3, 32'h0, STD, 1'b0, 2'd0, '0);
        lane_write(2, 32'h708, NTB, 1'b0, 2'd3, 32'h70C, STD, 1'b0, 2'd3, '0);
        lane_write(1, 32'h710, STD, 1'b0, 2'd3, 32'h0, STD, 1'b0, 2'd0, '0);
        cycle();
        cycle();
        checks++;
        if (pkt_valid_o !== 1'b1 || pkt_iaddr_o !== 32'h700 || wr_to != 0) begin
            failures++;
            $display("FAIL mid_pre got=%b/%h exp=1/00000700", pkt_valid_o, pkt_iaddr_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (pkt_valid_o !== 1'b0 || uop_ready_o !== 1'b1 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b%b%b exp=010", pkt_valid_o, uop_ready_o, overflow_o);
        end
        checks++;
        if (pkt_iaddr_o !== '0 || pkt_exc_o !== '0) begin
            failures++;
            $display("FAIL mid_reset_pkt got=%h/%h exp=0/0", pkt_iaddr_o, pkt_exc_o);
        end
        cycle();
        rst_i = 1'b0;
        pkt_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        checks++;
        if (pq.size() !== 0 || pkt_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_stale got=%0d/%b exp=0/0", pq.size(), pkt_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_block();
        test_exc_latency();
        test_priv_change();
        test_saturation();
        test_overflow();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
